// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Score player for the two-channel square-wave note generator. It fetches
//   {dur, div_left, div_right} entries from a synchronous score ROM, holds each
//   note's dividers for dur beats and handles play/pause/stop/loop control.
//   It also owns the 3-bit volume register (range 1..5) fed to the generator.
//
//   Optional feature macro: NOTE_GAP_EN
//     When defined, the last GAP_CYCLES cycles of each note's final beat are
//     silent (articulation gap). If the beat period is not longer than
//     GAP_CYCLES, the whole last beat is silent.
//     When undefined, the dividers are held for the full note duration.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   play              pulse: start from IDLE / resume from PAUSE
//   pause             pulse: pause while PLAY
//   stop              pulse: abort to IDLE (highest priority)
//   loop_en           level: restart at address 0 on end-of-score
//   tempo_sel[1:0]    beat period = BEAT_DIV >> tempo_sel, latched per note
//   vol_up, vol_down  pulses: saturating volume step
//   score_addr        registered ROM address
//   score_data[51:0]  {dur[51:44], div_left[43:22], div_right[21:0]}, 1-cycle latency
//   note_div_left/right  dividers to the note generator (22'd1 = silence)
//   volume[2:0]       volume to the note generator
//   playing           high in FETCH/LOAD/PLAY
//   done              1-cycle pulse at end of score when loop_en=0
//   state_dbg[2:0]    current FSM state encoding
//
// Control handshake: all controls are single-cycle pulses sampled on the
//   rising clock edge; there is no back-pressure. Priority stop > play > pause.
// -----------------------------------------------------------------------------
module note_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int BEAT_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  input  logic              vol_up,
  input  logic              vol_down,
  output logic [ADDR_W-1:0] score_addr,
  input  logic [51:0]       score_data,
  output logic [21:0]       note_div_left,
  output logic [21:0]       note_div_right,
  output logic [2:0]        volume,
  output logic              playing,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W = $clog2(BEAT_DIV + 1);
  localparam logic [CNT_W-1:0] BEAT = CNT_W'(BEAT_DIV);
  localparam logic [21:0] SILENCE = 22'd1;

`ifdef NOTE_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [7:0]       beats_left;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] period;
  logic [21:0]      saved_left;
  logic [21:0]      saved_right;

  logic [7:0]       rom_dur;
  logic [21:0]      rom_left;
  logic [21:0]      rom_right;
  logic [CNT_W-1:0] period_sel;

  assign rom_dur    = score_data[51:44];
  assign rom_left   = score_data[43:22];
  assign rom_right  = score_data[21:0];
  assign period_sel = BEAT >> tempo_sel;
  assign state_dbg  = state;

  // True when the counter position (bl, cnt) lies inside the articulation gap.
  // Evaluated on the *next* counter values so the registered dividers line up
  // exactly with the counter cycle they belong to.
  function automatic logic in_gap(input logic [7:0] bl, input logic [CNT_W-1:0] cnt,
                                  input logic [CNT_W-1:0] per);
    logic [31:0] pos;
    pos = 32'(cnt) + 32'(GAP_CYCLES);
    return GAP_EN && (bl == 8'd1) && (pos >= 32'(per));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      score_addr     <= '0;
      note_div_left  <= SILENCE;
      note_div_right <= SILENCE;
      volume         <= 3'd3;
      playing        <= 1'b0;
      done           <= 1'b0;
      beats_left     <= '0;
      beat_cnt       <= '0;
      period         <= '0;
      saved_left     <= SILENCE;
      saved_right    <= SILENCE;
    end else begin
      // Volume is independent of the player state and of stop.
      if (vol_up && !vol_down && volume < 3'd5)
        volume <= volume + 3'd1;
      else if (vol_down && !vol_up && volume > 3'd1)
        volume <= volume - 3'd1;

      done <= 1'b0;

      if (stop) begin
        state          <= S_IDLE;
        score_addr     <= '0;
        note_div_left  <= SILENCE;
        note_div_right <= SILENCE;
        playing        <= 1'b0;
        beats_left     <= '0;
        beat_cnt       <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (play) begin
              score_addr <= '0;
              state      <= S_FETCH;
              playing    <= 1'b1;
            end
          end

          // ROM latency cycle; the previous note keeps sounding.
          S_FETCH: state <= S_LOAD;

          S_LOAD: begin
            if (rom_dur == 8'd0) begin
              score_addr <= '0;
              if (loop_en) begin
                state <= S_FETCH;
              end else begin
                state          <= S_DONE;
                note_div_left  <= SILENCE;
                note_div_right <= SILENCE;
                playing        <= 1'b0;
                done           <= 1'b1;
              end
            end else begin
              saved_left  <= rom_left;
              saved_right <= rom_right;
              beats_left  <= rom_dur;
              beat_cnt    <= '0;
              period      <= period_sel;
              state       <= S_PLAY;
              if (in_gap(rom_dur, '0, period_sel)) begin
                note_div_left  <= SILENCE;
                note_div_right <= SILENCE;
              end else begin
                note_div_left  <= rom_left;
                note_div_right <= rom_right;
              end
            end
          end

          S_PLAY: begin
            if (pause && !play) begin
              state          <= S_PAUSE;
              playing        <= 1'b0;
              note_div_left  <= SILENCE;
              note_div_right <= SILENCE;
            end else if (beat_cnt == period - CNT_W'(1)) begin
              if (beats_left == 8'd1) begin
                // Final tick: address wraps naturally, no end-of-score implied.
                score_addr <= score_addr + ADDR_W'(1);
                beats_left <= '0;
                beat_cnt   <= '0;
                state      <= S_FETCH;
              end else begin
                beats_left <= beats_left - 8'd1;
                beat_cnt   <= '0;
                if (in_gap(beats_left - 8'd1, '0, period)) begin
                  note_div_left  <= SILENCE;
                  note_div_right <= SILENCE;
                end
              end
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
              if (in_gap(beats_left, beat_cnt + CNT_W'(1), period)) begin
                note_div_left  <= SILENCE;
                note_div_right <= SILENCE;
              end
            end
          end

          S_PAUSE: begin
            if (play) begin
              state   <= S_PLAY;
              playing <= 1'b1;
              if (in_gap(beats_left, beat_cnt, period)) begin
                note_div_left  <= SILENCE;
                note_div_right <= SILENCE;
              end else begin
                note_div_left  <= saved_left;
                note_div_right <= saved_right;
              end
            end
          end

          S_DONE: state <= S_IDLE;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//   Drives note_sequencer (ADDR_W=3, BEAT_DIV=8, GAP_CYCLES=2) with directed
//   scenarios and randomized control pulses. A behavioural player model tracks
//   elapsed cycles within the current note against dur*period and predicts
//   every output each cycle.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

  localparam int ADDR_W     = 3;
  localparam int BEAT_DIV   = 8;
  localparam int GAP_CYCLES = 2;
  localparam int ROM_N      = 1 << ADDR_W;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_LOAD  = 2;
  localparam int PH_PLAY  = 3;
  localparam int PH_PAUSE = 4;
  localparam int PH_DONE  = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              play = 0, pause = 0, stop = 0, loop_en = 0;
  logic [1:0]        tempo_sel = 0;
  logic              vol_up = 0, vol_down = 0;
  logic [ADDR_W-1:0] score_addr;
  logic [51:0]       score_data = '0;
  logic [21:0]       note_div_left, note_div_right;
  logic [2:0]        volume;
  logic              playing, done;
  logic [2:0]        state_dbg;

  note_sequencer #(.ADDR_W(ADDR_W), .BEAT_DIV(BEAT_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
    .loop_en(loop_en), .tempo_sel(tempo_sel), .vol_up(vol_up), .vol_down(vol_down),
    .score_addr(score_addr), .score_data(score_data),
    .note_div_left(note_div_left), .note_div_right(note_div_right),
    .volume(volume), .playing(playing), .done(done), .state_dbg(state_dbg)
  );

  // synchronous score ROM, 1-cycle latency
  logic [51:0] rom [ROM_N];
  always @(posedge clk) score_data <= rom[score_addr];

  // scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // behavioural player model
  int m_phase = PH_IDLE;
  int m_addr = 0, m_vol = 3, m_done = 0;
  int m_elapsed = 0, m_total = 0, m_per = 0;
  logic [21:0] m_l = 22'd1, m_r = 22'd1, m_held_l = 22'd1, m_held_r = 22'd1;

  function automatic bit model_silent();
`ifdef NOTE_GAP_EN
    return (m_elapsed >= m_total - GAP_CYCLES) && (m_elapsed >= m_total - m_per);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    logic [51:0] e;
    int d;
    if (vol_up && !vol_down && m_vol < 5) m_vol++;
    else if (vol_down && !vol_up && m_vol > 1) m_vol--;
    m_done = 0;
    if (stop) begin
      m_phase = PH_IDLE; m_addr = 0; m_l = 22'd1; m_r = 22'd1;
    end else begin
      case (m_phase)
        PH_IDLE:  if (play) begin m_addr = 0; m_phase = PH_FETCH; end
        PH_FETCH: m_phase = PH_LOAD;
        PH_LOAD: begin
          e = rom[m_addr];
          d = int'(e[51:44]);
          if (d == 0) begin
            m_addr = 0;
            if (loop_en) m_phase = PH_FETCH;
            else begin m_phase = PH_DONE; m_done = 1; m_l = 22'd1; m_r = 22'd1; end
          end else begin
            m_per = BEAT_DIV >> tempo_sel;
            m_total = d * m_per;
            m_elapsed = 0;
            m_held_l = e[43:22];
            m_held_r = e[21:0];
            m_phase = PH_PLAY;
          end
        end
        PH_PLAY: begin
          if (pause && !play) m_phase = PH_PAUSE;
          else begin
            m_elapsed++;
            if (m_elapsed == m_total) begin
              m_addr = (m_addr + 1) % ROM_N;
              m_phase = PH_FETCH;
            end
          end
        end
        PH_PAUSE: if (play) m_phase = PH_PLAY;
        default:  m_phase = PH_IDLE;
      endcase
    end
    // dividers: FETCH/LOAD keep whatever was sounding
    if (m_phase == PH_PLAY) begin
      if (model_silent()) begin m_l = 22'd1; m_r = 22'd1; end
      else begin m_l = m_held_l; m_r = m_held_r; end
    end else if (m_phase == PH_PAUSE || m_phase == PH_IDLE || m_phase == PH_DONE) begin
      m_l = 22'd1; m_r = 22'd1;
    end
  endtask

  // driver: one clock with the current inputs, then model update and compare
  task automatic run_cycle();
    bit exp_playing;
    @(posedge clk);
    model_step();
    #1;
    exp_playing = (m_phase == PH_FETCH || m_phase == PH_LOAD || m_phase == PH_PLAY);
    check_eq("score_addr", 32'(score_addr), 32'(m_addr));
    check_eq("div_left", 32'(note_div_left), 32'(m_l));
    check_eq("div_right", 32'(note_div_right), 32'(m_r));
    check_eq("volume", 32'(volume), 32'(m_vol));
    check_eq("playing", 32'(playing), 32'(exp_playing));
    check_eq("done", 32'(done), 32'(m_done));
    play = 0; pause = 0; stop = 0; vol_up = 0; vol_down = 0;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic load_basic_rom();
    for (int i = 0; i < ROM_N; i++) rom[i] = '0;
    rom[0] = {8'd2, 22'd1000, 22'd2000};
    rom[1] = {8'd1, 22'd3000, 22'd4000};
    rom[2] = {8'd0, 22'd0, 22'd0};
  endtask

  task automatic load_random_rom();
    for (int i = 0; i < ROM_N; i++) begin
      rom[i][51:44] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'(($urandom_range(1, 3)));
      rom[i][43:22] = ($urandom_range(0, 5) == 0) ? 22'd1 : 22'($urandom);
      rom[i][21:0]  = 22'($urandom);
    end
  endtask

  initial begin
    load_basic_rom();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_addr", 32'(score_addr), 32'd0);
    check_eq("rst_left", 32'(note_div_left), 32'd1);
    check_eq("rst_right", 32'(note_div_right), 32'd1);
    check_eq("rst_volume", 32'(volume), 32'd3);
    check_eq("rst_playing", 32'(playing), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 0;

    // volume stepping and saturation
    for (int i = 0; i < 4; i++) begin
      vol_up = 1;
      run_cycle();
      check_eq("vol_up_abs", 32'(volume), (i == 0) ? 32'd4 : 32'd5);
    end
    for (int i = 0; i < 6; i++) begin vol_down = 1; run_cycle(); end
    check_eq("vol_floor", 32'(volume), 32'd1);
    vol_up = 1; vol_down = 1; run_cycle();
    check_eq("vol_both", 32'(volume), 32'd1);
    vol_up = 1; run_cycle();
    vol_up = 1; vol_down = 1; run_cycle();
    check_eq("vol_both2", 32'(volume), 32'd2);

    // play the short score to the end, no loop
    loop_en = 0; tempo_sel = 0;
    play = 1; run_cycle();
    run_n(3);
    check_eq("note_a_left", 32'(note_div_left), 32'd1000);
    run_n(40);
    check_eq("end_idle_left", 32'(note_div_left), 32'd1);
    check_eq("end_idle_addr", 32'(score_addr), 32'd0);

    // same score looping; stop after a while
    loop_en = 1;
    play = 1; run_cycle();
    run_n(70);
    stop = 1; run_cycle();
    loop_en = 0;

    // pause at beat_cnt=5 of the first note, hold 20 cycles, resume
    play = 1; run_cycle();
    run_n(2 + 5);
    pause = 1; run_cycle();
    check_eq("pause_left", 32'(note_div_left), 32'd1);
    run_n(19);
    play = 1; run_cycle();
    check_eq("resume_left", 32'(note_div_left), 32'd1000);
    run_n(40);

    // stop asserted together with play during FETCH
    play = 1; run_cycle();
    check_eq("in_fetch", 32'(playing), 32'd1);
    stop = 1; play = 1; run_cycle();
    check_eq("stop_addr", 32'(score_addr), 32'd0);
    check_eq("stop_playing", 32'(playing), 32'd0);
    run_n(3);

    // fast tempo: short notes exercise the articulation gap when enabled
    rom[0] = {8'd1, 22'd500, 22'd600};
    rom[1] = {8'd2, 22'd700, 22'd800};
    rom[2] = {8'd0, 22'd0, 22'd0};
    tempo_sel = 2;
    play = 1; run_cycle();
    run_n(20);
    tempo_sel = 3;
    play = 1; run_cycle();
    run_n(15);

    // randomized control traffic over several random scores
    for (int r = 0; r < 4; r++) begin
      stop = 1; run_cycle();
      load_random_rom();
      for (int c = 0; c < 800; c++) begin
        int k;
        k = $urandom_range(0, 99);
        if (k < 5) play = 1;
        else if (k < 8) pause = 1;
        else if (k < 9) stop = 1;
        if ($urandom_range(0, 19) == 0) vol_up = 1;
        if ($urandom_range(0, 19) == 0) vol_down = 1;
        if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
        if ($urandom_range(0, 39) == 0) tempo_sel = 2'($urandom_range(0, 3));
        run_cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
